// File: rtl/mul_sequencer_if.sv
// Start/operand/result bundle between the CPU pipeline and the multiply sequencer.
interface mul_sequencer_if;
  logic        iStart;
  logic [1:0]  iMode;
  logic [15:0] iA;
  logic [15:0] iB;
  logic        oBusy;
  logic        oStall;
  logic        oDone;
  logic        oError;
  logic [15:0] oResultLow;
  logic [15:0] oResultHigh;

  modport master (
    output iStart, iMode, iA, iB,
    input  oBusy, oStall, oDone, oError, oResultLow, oResultHigh
  );

  modport slave (
    input  iStart, iMode, iA, iB,
    output oBusy, oStall, oDone, oError, oResultLow, oResultHigh
  );
endinterface

// File: rtl/mul_sequencer.sv
// Iterative shift-and-add multiplier: 4-bit, unsigned 16x16 and sign-magnitude 16x16,
// one multiplier bit per RUN cycle, sign fix-up in SIGN, one-cycle result pulse in DONE.
module mul_sequencer (
  input  logic            Clock,
  input  logic            Reset,
  mul_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_e;
  typedef enum logic [1:0] {
    MODE_MUL4 = 2'b00,
    MODE_MUL2 = 2'b01,
    MODE_SMUL = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  state_e      state_q;
  mode_e       mode_q;
  logic        sign_q;
  logic [31:0] acc_q;
  logic [31:0] mcand_q;
  logic [15:0] mplier_q;
  logic [4:0]  count_q;
  logic        busy_q;
  logic        stall_q;
  logic        done_q;
  logic        err_q;
  logic [15:0] res_lo_q;
  logic [15:0] res_hi_q;

  logic [31:0] acc_d;
  logic [31:0] result_d;
  mode_e       mode_in;

  assign mode_in = mode_e'(bus.iMode);

  always_comb begin
    acc_d    = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
    result_d = acc_q;
    // Magnitudes are 15 bits, so bit 30 of the product is free; sign suppressed for a zero product.
    if (mode_q == MODE_SMUL)
      result_d = {sign_q & (|acc_q[30:0]), acc_q[30:0]};
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= IDLE;
      mode_q   <= MODE_MUL4;
      sign_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      stall_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.iStart) begin
            mode_q <= mode_in;
            sign_q <= bus.iA[15] ^ bus.iB[15];
            acc_q  <= '0;
            case (mode_in)
              MODE_MUL4: begin
                mcand_q  <= {28'd0, bus.iA[3:0]};
                mplier_q <= {12'd0, bus.iB[3:0]};
                count_q  <= 5'd4;
              end
              MODE_MUL2: begin
                mcand_q  <= {16'd0, bus.iA};
                mplier_q <= bus.iB;
                count_q  <= 5'd16;
              end
              MODE_SMUL: begin
                mcand_q  <= {17'd0, bus.iA[14:0]};
                mplier_q <= {1'b0, bus.iB[14:0]};
                count_q  <= 5'd16;
              end
              default: begin
                mcand_q  <= '0;
                mplier_q <= '0;
                count_q  <= '0;
              end
            endcase
            busy_q <= 1'b1;
            if (mode_in == MODE_RSVD) begin
              state_q  <= DONE;
              stall_q  <= 1'b0;
              done_q   <= 1'b1;
              err_q    <= 1'b1;
              res_lo_q <= '0;
              res_hi_q <= '0;
            end else begin
              state_q <= RUN;
              stall_q <= 1'b1;
            end
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q - 5'd1;
          if (count_q == 5'd1) state_q <= SIGN;
        end
        SIGN: begin
          res_lo_q <= result_d[15:0];
          res_hi_q <= result_d[31:16];
          done_q   <= 1'b1;
          stall_q  <= 1'b0;
          state_q  <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          stall_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.oBusy       = busy_q;
  assign bus.oStall      = stall_q;
  assign bus.oDone       = done_q;
  assign bus.oError      = err_q;
  assign bus.oResultLow  = res_lo_q;
  assign bus.oResultHigh = res_hi_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed-vector bench for mul_sequencer: table of operations plus reset and
// restart-while-busy sequences, all expectations hand-computed.
module tb_mul_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  mul_sequencer_if bus ();

  mul_sequencer dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        err;
    int unsigned lat;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives the operation at a falling edge; returns #1 after the sampling edge with iStart low.
  task automatic start_op(input logic [1:0] mode, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.iMode  = mode;
    bus.iA     = a;
    bus.iB     = b;
    bus.iStart = 1'b1;
    @(posedge clk);
    #1 bus.iStart = 1'b0;
  endtask

  // Called #1 after the sampling edge; counts further edges until oDone.
  task automatic wait_done(input string tag, input int unsigned lat,
                           input logic [15:0] hi, input logic [15:0] lo, input logic err);
    int unsigned cycles = 0;
    bit          seen   = 1'b0;
    bit          busy_ok = 1'b1;
    while (!seen && cycles < 40) begin
      if (bus.oDone) seen = 1'b1;
      else begin
        if (!(bus.oBusy && bus.oStall)) busy_ok = 1'b0;
        @(posedge clk);
        #1 cycles++;
      end
    end
    check({tag, " latency"}, seen ? cycles : 32'hDEAD, lat);
    if (lat > 0) check({tag, " busy/stall while running"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " hi"}, {16'd0, bus.oResultHigh}, {16'd0, hi});
    check({tag, " lo"}, {16'd0, bus.oResultLow}, {16'd0, lo});
    check({tag, " err"}, {31'd0, bus.oError}, {31'd0, err});
    check({tag, " busy/stall at done"}, {30'd0, bus.oBusy, bus.oStall}, 32'd2);
    @(posedge clk);
    #1;
    check({tag, " idle after done"}, {29'd0, bus.oBusy, bus.oDone, bus.oError}, 32'd0);
    check({tag, " result held"}, {bus.oResultHigh, bus.oResultLow}, {hi, lo});
  endtask

  initial begin
    vecs[0]  = '{2'b00, 16'h0002, 16'h0004, 16'h0000, 16'h0008, 1'b0, 5};
    vecs[1]  = '{2'b00, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h00E1, 1'b0, 5};
    vecs[2]  = '{2'b00, 16'h012F, 16'h0ABE, 16'h0000, 16'h00D2, 1'b0, 5};
    vecs[3]  = '{2'b01, 16'h1129, 16'h0036, 16'h0003, 16'h9EA6, 1'b0, 17};
    vecs[4]  = '{2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17};
    vecs[5]  = '{2'b11, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b1, 0};
    vecs[6]  = '{2'b01, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 17};
    vecs[7]  = '{2'b01, 16'h0100, 16'h0100, 16'h0001, 16'h0000, 1'b0, 17};
    vecs[8]  = '{2'b10, 16'h8002, 16'h0008, 16'h8000, 16'h0010, 1'b0, 17};
    vecs[9]  = '{2'b10, 16'h8000, 16'h0005, 16'h0000, 16'h0000, 1'b0, 17};
    vecs[10] = '{2'b10, 16'h8003, 16'h8004, 16'h0000, 16'h000C, 1'b0, 17};
    vecs[11] = '{2'b10, 16'h7FFF, 16'hFFFF, 16'hBFFF, 16'h0001, 1'b0, 17};

    // iStart held during reset must be discarded.
    rst_n      = 1'b0;
    bus.iStart = 1'b1;
    bus.iMode  = 2'b00;
    bus.iA     = 16'h0002;
    bus.iB     = 16'h0004;
    repeat (3) @(posedge clk);
    #1;
    check("reset flags", {28'd0, bus.oBusy, bus.oStall, bus.oDone, bus.oError}, 32'd0);
    check("reset results", {bus.oResultHigh, bus.oResultLow}, 32'd0);

    // First edge out of reset with iStart high is accepted.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 bus.iStart = 1'b0;
    check("first accept busy", {31'd0, bus.oBusy}, 32'd1);
    wait_done("first op", 5, 16'h0000, 16'h0008, 1'b0);

    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].mode, vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), vecs[i].lat, vecs[i].hi, vecs[i].lo, vecs[i].err);
    end

    // iStart stuck high with operands scrambled every cycle during the run.
    begin
      int unsigned cycles = 0;
      int unsigned dones  = 0;
      start_op(2'b01, 16'h1129, 16'h0036);
      bus.iStart = 1'b1;
      while (dones == 0 && cycles < 40) begin
        @(negedge clk);
        bus.iA    = 16'($urandom);
        bus.iB    = 16'($urandom);
        bus.iMode = 2'($urandom);
        @(posedge clk);
        #1 cycles++;
        if (bus.oDone) dones++;
      end
      check("stuck start latency", cycles, 32'd17);
      check("stuck start result", {bus.oResultHigh, bus.oResultLow}, 32'h0003_9EA6);
      @(posedge clk);
      #1;
      check("no restart from DONE", {30'd0, bus.oBusy, bus.oDone}, 32'd0);
      bus.iStart = 1'b0;
    end

    // Reset landing on edge 8 of a MUL2 run.
    start_op(2'b01, 16'hFFFF, 16'hFFFF);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid-run reset flags", {28'd0, bus.oBusy, bus.oStall, bus.oDone, bus.oError}, 32'd0);
    check("mid-run reset results", {bus.oResultHigh, bus.oResultLow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int unsigned stray = 0;
      repeat (20) begin
        @(posedge clk);
        #1 if (bus.oDone || bus.oBusy) stray++;
      end
      check("no done after reset", stray, 32'd0);
    end
    start_op(2'b01, 16'h1129, 16'h0036);
    wait_done("post-reset op", 17, 16'h0003, 16'h9EA6, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 The block SHALL have one clock, and reset SHALL be synchronous and active-low.
REQ-002 Clock  in  1  rising-edge system clock.
REQ-003 Reset  in  1  synchronous active-low reset, sampled on the Clock rising edge.
REQ-004 iStart  in  1  request to start a multiply; honoured only in IDLE.
REQ-005 iMode  in  2  operation select:
- 00 MUL4bits: unsigned iA[3:0] x iB[3:0].
- 01 MUL2: unsigned 16x16.
- 10 SMUL: sign-magnitude 16x16 (bit15 = sign, bits14:0 = magnitude).
- 11 reserved.
REQ-006 iA, iB  in  16 each  operands.
REQ-007 oBusy  out  1  high in every state except IDLE.
REQ-008 oStall  out  1  CPU pipeline hold; equals oBusy AND NOT oDone.
REQ-009 oDone  out  1  one-cycle completion pulse.
REQ-010 oError  out  1  one-cycle pulse coincident with oDone for reserved mode.
REQ-011 oResultLow  out  16  result bits 15:0, written to the destination register.
REQ-012 oResultHigh  out  16  result bits 31:16, written to R8.

Function
REQ-013 The state machine SHALL have states IDLE, RUN, SIGN and DONE.
REQ-014 IDLE with iStart=1 SHALL do the following on the sampling edge:
- latch iMode;
- latch the multiplicand and multiplier magnitudes (MUL4bits: zero-extended nibbles; MUL2: full 16 bits; SMUL: bits14:0);
- clear the 32-bit accumulator;
- load the iteration counter with N (4 for MUL4bits, 16 for MUL2/SMUL);
- enter RUN.
REQ-015 Each RUN cycle SHALL perform the following, and RUN SHALL go to SIGN on the edge where the counter reaches 0:
- if multiplier LSB = 1, add the multiplicand to the accumulator;
- shift the multiplicand left by 1;
- shift the multiplier right by 1;
- decrement the counter.
REQ-016 SIGN SHALL apply sign handling and go to DONE:
- SMUL: result[31] = iA[15] XOR iB[15], result[30:0] = magnitude product;
- SMUL with a zero magnitude product: result[31] = 0 (no negative zero);
- other modes: the accumulator unchanged.
REQ-017 DONE SHALL assert oDone for exactly one cycle, load oResultHigh/oResultLow, and return to IDLE on the next edge.
REQ-018 oDone SHALL be high in the cycle after the (N+1)th rising edge following the iStart-sampling edge: 5 edges for MUL4bits, 17 edges for MUL2/SMUL.
REQ-019 Reserved mode 11 SHALL go from IDLE straight to DONE with results 0x0000/0x0000 and oError=1.
REQ-020 iStart while not in IDLE, including the DONE cycle, SHALL be ignored; no queuing.
REQ-021 iA, iB and iMode changes after the sampling edge SHALL NOT affect the operation in progress.
REQ-022 oResultHigh/oResultLow SHALL hold their last value until the next DONE.
REQ-023 The accumulator SHALL be 32 bits and SHALL never overflow: the maximum is 0xFFFF x 0xFFFF = 0xFFFE0001.
REQ-024 MUL4bits results SHALL have oResultHigh = 0x0000 and oResultLow[15:8] = 0x00.

Reset
REQ-025 Reset=0 at a rising edge SHALL take priority over all other activity, including mid-RUN/SIGN/DONE, and SHALL set:
- state = IDLE;
- oBusy = oStall = oDone = oError = 0;
- oResultHigh = oResultLow = 0x0000;
- accumulator = counter = 0.
REQ-026 iStart sampled on the same edge as Reset=0 SHALL be discarded.
REQ-027 The first operation SHALL be accepted on the first edge with Reset=1 and iStart=1.

Verification
REQ-028 MUL4bits, iA=0x0002, iB=0x0004 -> oDone 5 edges after the start edge, oResultHigh=0x0000, oResultLow=0x0008, oError=0.
REQ-029 SMUL, iA=0x8002 (-2), iB=0x0008 -> oDone after 17 edges, oResultHigh=0x8000, oResultLow=0x0010; SMUL iA=0x8000, iB=0x0005 -> 0x0000/0x0000 (no negative zero).
REQ-030 MUL2, iA=0x1129, iB=0x0036 -> 0x0003/0x9EA6; MUL2 0xFFFF x 0xFFFF -> 0xFFFE/0x0001.
REQ-031 iStart held high with operands changed every cycle during RUN -> a single oDone, result of the originally latched operands; next operation starts only on an edge in IDLE.
REQ-032 Reset=0 asserted at edge 8 of a MUL2 run -> next cycle IDLE, all outputs 0, no oDone; a new MUL2 issued afterwards completes after 17 edges with the correct result.
REQ-033 Mode 11 -> oDone and oError high together for one cycle one edge after start, results 0x0000/0x0000, prior results overwritten.
